// File: rtl/relu_requant_maxpool.sv
// Convolution output stage: bias add, arithmetic shift, ReLU with 8-bit
// saturation, then a 2x2 stride-2 max-pool over a raster-ordered frame.
// Pipeline: stage 1 registers the requantised pixel, stage 2 pools it.
module relu_requant_maxpool #(
  parameter int NUM_CHANNELS = 4,
  parameter int IMG_WIDTH    = 8,
  parameter int IMG_HEIGHT   = 8,
  parameter int SHIFT        = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic [32*NUM_CHANNELS-1:0] pixel_vector_in,
  input  logic [32*NUM_CHANNELS-1:0] bias,
  output logic                      valid_out,
  output logic [8*NUM_CHANNELS-1:0] pixel_vector_out,
  output logic                      frame_done
);

  localparam int DW       = 8 * NUM_CHANNELS;
  localparam int CW       = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW       = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_DEPTH = (IMG_WIDTH / 2 > 0) ? IMG_WIDTH / 2 : 1;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  // Reject geometries the pooling window cannot tile and shifts beyond the sum width
  if (IMG_WIDTH < 2 || (IMG_WIDTH % 2) != 0) begin : g_bad_width
    $error("relu_requant_maxpool: IMG_WIDTH must be even and >= 2");
  end
  if (IMG_HEIGHT < 2 || (IMG_HEIGHT % 2) != 0) begin : g_bad_height
    $error("relu_requant_maxpool: IMG_HEIGHT must be even and >= 2");
  end
  if (SHIFT < 0 || SHIFT > 31) begin : g_bad_shift
    $error("relu_requant_maxpool: SHIFT must be in 0..31");
  end

  // ---------------------------------------------------------------------
  // Stage 1: requantisation
  // ---------------------------------------------------------------------
  logic [DW-1:0] q_next;
  logic [DW-1:0] q_reg;
  logic          s1_valid_reg;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_requant
    logic signed [32:0] sum;
    logic signed [32:0] shifted;
    logic        [7:0]  q;

    // 33-bit sum holds any pair of 32-bit operands without wrapping
    assign sum = $signed({pixel_vector_in[32*gi+31], pixel_vector_in[32*gi +: 32]})
               + $signed({bias[32*gi+31], bias[32*gi +: 32]});
    assign shifted = sum >>> SHIFT;

    // ReLU then clamp to the unsigned 8-bit range
    always_comb begin
      q = shifted[7:0];
      if (shifted[32]) begin
        q = 8'd0;
      end else if (|shifted[31:8]) begin
        q = 8'hFF;
      end
    end

    assign q_next[8*gi +: 8] = q;
  end

  // Capture the requantised pixel; its valid flag tracks valid_in one cycle later
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      q_reg        <= '0;
    end else begin
      s1_valid_reg <= valid_in;
      if (valid_in) begin
        q_reg <= q_next;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: 2x2 max-pool
  // ---------------------------------------------------------------------
  logic [CW-1:0]    col_reg;
  logic [RW-1:0]    row_reg;
  logic [DW-1:0]    h_reg;
  logic [DW-1:0]    linebuf [LB_DEPTH];
  logic [LB_AW-1:0] lb_idx;
  logic [DW-1:0]    lb_rd;
  logic [DW-1:0]    pair_max;
  logic [DW-1:0]    win_max;
  logic             col_last;
  logic             row_last;

  // Each line-buffer slot covers one column pair of the window row above
  assign lb_idx   = LB_AW'(col_reg >> 1);
  assign lb_rd    = linebuf[lb_idx];
  assign col_last = (col_reg == CW'(IMG_WIDTH - 1));
  assign row_last = (row_reg == RW'(IMG_HEIGHT - 1));

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_pool
    logic [7:0] h_c;
    logic [7:0] cur_c;
    logic [7:0] lb_c;
    logic [7:0] pair_c;

    assign h_c    = h_reg[8*gi +: 8];
    assign cur_c  = q_reg[8*gi +: 8];
    assign lb_c   = lb_rd[8*gi +: 8];
    assign pair_c = (h_c > cur_c) ? h_c : cur_c;

    assign pair_max[8*gi +: 8] = pair_c;
    assign win_max[8*gi +: 8]  = (lb_c > pair_c) ? lb_c : pair_c;
  end

  // Top row of a window stores its horizontal maximum for the row below;
  // contents need no reset since every slot is written before it is read
  always_ff @(posedge clock) begin
    if (s1_valid_reg && col_reg[0] && !row_reg[0]) begin
      linebuf[lb_idx] <= pair_max;
    end
  end

  // Raster position, horizontal hold and registered pooled output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_reg          <= '0;
      row_reg          <= '0;
      h_reg            <= '0;
      valid_out        <= 1'b0;
      pixel_vector_out <= '0;
      frame_done       <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (s1_valid_reg) begin
        if (!col_reg[0]) begin
          h_reg <= q_reg;
        end else if (row_reg[0]) begin
          pixel_vector_out <= win_max;
          valid_out        <= 1'b1;
          frame_done       <= row_last && col_last;
        end

        if (col_last) begin
          col_reg <= '0;
          if (row_last) begin
            row_reg <= '0;
          end else begin
            row_reg <= row_reg + 1'b1;
          end
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_requant_maxpool.sv
// Randomised and directed bench for relu_requant_maxpool. Two instances
// (SHIFT=0 and SHIFT=2) share stimulus; a frame-array reference model
// predicts every pooled pixel, its frame_done flag and its arrival cycle.
module tb_relu_requant_maxpool;

  localparam int NC = 2;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clock;
  logic          reset;
  logic          valid_in;
  logic [63:0]   pixel_vector_in;
  logic [63:0]   bias;
  logic          v0, v2;
  logic [15:0]   o0, o2;
  logic          fd0, fd2;

  relu_requant_maxpool #(.NUM_CHANNELS(NC), .IMG_WIDTH(W), .IMG_HEIGHT(H), .SHIFT(0)) dut0 (
    .clock(clock), .reset(reset), .valid_in(valid_in),
    .pixel_vector_in(pixel_vector_in), .bias(bias),
    .valid_out(v0), .pixel_vector_out(o0), .frame_done(fd0)
  );

  relu_requant_maxpool #(.NUM_CHANNELS(NC), .IMG_WIDTH(W), .IMG_HEIGHT(H), .SHIFT(2)) dut2 (
    .clock(clock), .reset(reset), .valid_in(valid_in),
    .pixel_vector_in(pixel_vector_in), .bias(bias),
    .valid_out(v2), .pixel_vector_out(o2), .frame_done(fd2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] d0;
    logic [15:0] d2;
    bit          fd;
    longint      due;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] log0[$];
  logic [15:0] log2[$];
  int          m0[NC][W*H];
  int          m2[NC][W*H];
  int          midx = 0;
  int          fd_count = 0;

  function automatic int requant(input logic [31:0] a, input logic [31:0] b, input int sh);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    s = s >>> sh;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return int'(s);
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic model_pixel(input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] b0, input logic [31:0] b1);
    int r, c, p;
    exp_t e;
    m0[0][midx] = requant(a0, b0, 0);
    m0[1][midx] = requant(a1, b1, 0);
    m2[0][midx] = requant(a0, b0, 2);
    m2[1][midx] = requant(a1, b1, 2);
    r = midx / W;
    c = midx % W;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      for (int ch = 0; ch < NC; ch++) begin
        p = max4(m0[ch][(r-1)*W+c-1], m0[ch][(r-1)*W+c], m0[ch][r*W+c-1], m0[ch][r*W+c]);
        e.d0[8*ch +: 8] = p[7:0];
        p = max4(m2[ch][(r-1)*W+c-1], m2[ch][(r-1)*W+c], m2[ch][r*W+c-1], m2[ch][r*W+c]);
        e.d2[8*ch +: 8] = p[7:0];
      end
      e.fd  = (midx == W*H-1);
      e.due = cyc + 2;
      exp_q.push_back(e);
    end
    midx = (midx + 1) % (W*H);
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      check("missing_output_cycle", cyc, e.due);
    end
    if (v0 || v2) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("valid_s0", v0, 1);
        check("valid_s2", v2, 1);
        check("latency", cyc, e.due);
        check("data_s0", o0, e.d0);
        check("data_s2", o2, e.d2);
        check("frame_done_s0", fd0, e.fd);
        check("frame_done_s2", fd2, e.fd);
        log0.push_back(o0);
        log2.push_back(o2);
        $display("out cyc=%0d s0=%h s2=%h fd=%0d", cyc, o0, o2, fd0);
      end
      if (fd0) fd_count++;
    end else begin
      check("idle_frame_done", {fd0, fd2}, 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] b0, input logic [31:0] b1, input int gap);
    repeat (gap) begin
      @(posedge clock); #1;
      valid_in = 1'b0;
    end
    @(posedge clock); #1;
    valid_in        = 1'b1;
    pixel_vector_in = {a1, a0};
    bias            = {b1, b0};
    model_pixel(a0, a1, b0, b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      valid_in = 1'b0;
    end
  endtask

  task automatic drain();
    idle(6);
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic raster(input int off, input int maxgap);
    for (int i = 0; i < W*H; i++)
      send(32'(i + off), 32'(15 - i + off), 32'd0, 32'd0, int'($urandom_range(0, maxgap)));
  endtask

  task automatic const_frame(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < W*H; i++) send(a, a, b, b, 0);
    drain();
  endtask

  int exp_c0[4] = '{5, 7, 13, 15};
  int exp_c1[4] = '{15, 13, 7, 5};
  int exp_b0[4] = '{105, 107, 113, 115};

  initial begin
    int fd_before;
    logic [31:0] ra0, ra1, rb0, rb1;

    reset = 1'b1;
    valid_in = 1'b0;
    pixel_vector_in = '0;
    bias = '0;
    #1;
    check("reset_valid", {v0, v2}, 0);
    check("reset_data", {o0, o2}, 0);
    check("reset_done", {fd0, fd2}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // raster frame with known answers
    log0.delete(); log2.delete();
    raster(0, 0);
    drain();
    check("raster_count", log0.size(), 4);
    for (int k = 0; k < 4 && k < log0.size(); k++) begin
      check("raster_ch0", log0[k][7:0], exp_c0[k]);
      check("raster_ch1", log0[k][15:8], exp_c1[k]);
    end

    // saturation / ReLU / no-wrap corners
    log0.delete(); log2.delete();
    const_frame(32'd400, 32'd0);
    check("arith_400_s2", log2[log2.size()-1][7:0], 100);
    const_frame(32'd1023, 32'd0);
    check("arith_1023_s2", log2[log2.size()-1][7:0], 255);
    const_frame(32'hFFFFFF9C, 32'd0);
    check("arith_neg100_s2", log2[log2.size()-1][7:0], 0);
    const_frame(32'h7FFFFFFF, 32'd1);
    check("arith_nowrap_s2", log2[log2.size()-1][7:0], 255);
    check("arith_nowrap_s0", log0[log0.size()-1][7:0], 255);
    const_frame(32'd5, 32'hFFFFFFF6);
    check("arith_biasneg_s0", log0[log0.size()-1][7:0], 0);

    // gaps between valid pixels
    log0.delete(); log2.delete();
    raster(0, 3);
    drain();
    check("gap_count", log0.size(), 4);
    for (int k = 0; k < 4 && k < log0.size(); k++)
      check("gap_ch0", log0[k][7:0], exp_c0[k]);

    // reset mid-frame: 6 pixels, let the first window emerge, then reset
    for (int i = 0; i < 6; i++) send(32'(i + 50), 32'(i + 60), 32'd0, 32'd0, 0);
    idle(1);
    @(posedge clock);
    #7;
    reset = 1'b1;
    #1;
    check("midreset_valid", {v0, v2}, 0);
    check("midreset_data", {o0, o2}, 0);
    check("midreset_done", {fd0, fd2}, 0);
    exp_q.delete();
    midx = 0;
    @(negedge clock);
    reset = 1'b0;
    log0.delete(); log2.delete();
    raster(0, 0);
    drain();
    check("postreset_count", log0.size(), 4);
    for (int k = 0; k < 4 && k < log0.size(); k++)
      check("postreset_ch0", log0[k][7:0], exp_c0[k]);

    // back-to-back frames
    log0.delete(); log2.delete();
    fd_before = fd_count;
    raster(0, 0);
    raster(100, 0);
    drain();
    check("b2b_count", log0.size(), 8);
    check("b2b_frame_done", fd_count - fd_before, 2);
    for (int k = 0; k < 4 && k + 4 < log0.size(); k++)
      check("b2b_ch0", log0[k+4][7:0], exp_b0[k]);

    // randomised frames, bias changing per pixel, random gaps
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < W*H; i++) begin
        ra0 = ($urandom_range(0, 3) == 0) ? $urandom : 32'(int'($urandom_range(0, 1400)) - 200);
        ra1 = ($urandom_range(0, 3) == 0) ? $urandom : 32'(int'($urandom_range(0, 1400)) - 200);
        rb0 = ($urandom_range(0, 7) == 0) ? $urandom : 32'(int'($urandom_range(0, 100)) - 50);
        rb1 = 32'(int'($urandom_range(0, 100)) - 50);
        send(ra0, ra1, rb0, rb1, (f % 2 == 0) ? 0 : int'($urandom_range(0, 3)));
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
